// File: rtl/uart_eth_tx_loader_pkg.sv
// Shared types and constants for the UART-to-Ethernet Tx loader.
package eth_test_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LEN_LO,
        RX_DATA,
        WR_WORD,
        WAIT_RTS,
        WAIT_DONE,
        DRAIN,
        ACK,
        ACK_WAIT
    } state_t;

    localparam logic [7:0] ST_OK      = 8'hA5;
    localparam logic [7:0] ST_LEN_ERR = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT = 8'hE2;
    localparam logic [7:0] ST_NO_DONE = 8'hE3;

    localparam int ACK_WAIT_LIMIT = 16;

    function automatic logic len_valid(input logic [15:0] n, input int max_words);
        return (n != 16'd0) && (32'(n) <= max_words);
    endfunction

endpackage

// File: rtl/uart_eth_tx_loader_if.sv
// UART byte link plus ethernet_module Tx buffer port, seen from the loader (master).
interface uart_eth_tx_loader_if;

    logic        uart_rdy;
    logic [7:0]  uart_dout;
    logic        uart_rdy_clr;
    logic        uart_tx_busy;
    logic [7:0]  uart_din;
    logic        uart_wr_en;
    logic        tx_ready_to_write;
    logic        tx_ready_to_send;
    logic        tx_done;
    logic [31:0] tx_data_in;
    logic        tx_valid;
    logic        tx_send;
    logic        tx_clear;

    modport master (
        input  uart_rdy, uart_dout, uart_tx_busy,
        input  tx_ready_to_write, tx_ready_to_send, tx_done,
        output uart_rdy_clr, uart_din, uart_wr_en,
        output tx_data_in, tx_valid, tx_send, tx_clear
    );

    modport slave (
        output uart_rdy, uart_dout, uart_tx_busy,
        output tx_ready_to_write, tx_ready_to_send, tx_done,
        input  uart_rdy_clr, uart_din, uart_wr_en,
        input  tx_data_in, tx_valid, tx_send, tx_clear
    );

endinterface

// File: rtl/uart_eth_tx_loader_byte_taker.sv
// Takes each pending UART byte exactly once: rdy_seen blocks re-acceptance until
// the receiver has dropped uart_rdy in response to the rdy_clr pulse.
module uart_byte_taker (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       uart_rdy,
    input  logic [7:0] uart_dout,
    output logic       uart_rdy_clr,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic rdy_seen;

    assign byte_valid = en && uart_rdy && !rdy_seen;
    assign byte_data  = uart_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_seen     <= 1'b0;
            uart_rdy_clr <= 1'b0;
        end else begin
            uart_rdy_clr <= byte_valid;
            if (byte_valid)
                rdy_seen <= 1'b1;
            else if (!uart_rdy)
                rdy_seen <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_eth_tx_loader.sv
// Packs a length-prefixed UART byte stream into 32-bit words for the Ethernet Tx
// buffer, triggers transmission and reports a one-byte status back to the host.
module uart_eth_tx_loader
    import eth_test_pkg::*;
#(
    parameter int MAX_WORDS      = 512,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk_100_mhz,
    input  logic                 rst,
    uart_eth_tx_loader_if.master bus,
    output logic                 busy,
    output logic [15:0]          frames_sent
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] tmo;
    logic [7:0]    len_hi;
    logic [7:0]    status;
    logic [15:0]   len;
    logic [15:0]   word_cnt;
    logic [1:0]    byte_cnt;
    logic [4:0]    ack_cnt;
    logic          ack_seen;
    logic          take_en;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          rdy_clr;
    logic [15:0]   len_rx;

    // Bytes are only taken where the frame can use or discard them; elsewhere they wait in the UART.
    assign take_en = (state == IDLE) || (state == LEN_LO) || (state == RX_DATA) || (state == DRAIN);
    assign len_rx  = {len_hi, byte_data};
    assign busy    = (state != IDLE);

    assign bus.uart_rdy_clr = rdy_clr;

    uart_byte_taker u_taker (
        .clk          (clk_100_mhz),
        .rst          (rst),
        .en           (take_en),
        .uart_rdy     (bus.uart_rdy),
        .uart_dout    (bus.uart_dout),
        .uart_rdy_clr (rdy_clr),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data)
    );

    always_ff @(posedge clk_100_mhz or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tmo            <= '0;
            len_hi         <= '0;
            status         <= '0;
            len            <= '0;
            word_cnt       <= '0;
            byte_cnt       <= '0;
            ack_cnt        <= '0;
            ack_seen       <= 1'b0;
            frames_sent    <= '0;
            bus.tx_data_in <= '0;
            bus.tx_valid   <= 1'b0;
            bus.tx_send    <= 1'b0;
            bus.tx_clear   <= 1'b0;
            bus.uart_din   <= '0;
            bus.uart_wr_en <= 1'b0;
        end else begin
            bus.tx_valid   <= 1'b0;
            bus.tx_send    <= 1'b0;
            bus.tx_clear   <= 1'b0;
            bus.uart_wr_en <= 1'b0;
            // Free-running decrement; every state entry or accepted byte reloads it below.
            if (tmo != '0)
                tmo <= tmo - 1'b1;

            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        len_hi <= byte_data;
                        tmo    <= TMO_LOAD;
                        state  <= LEN_LO;
                    end
                end

                LEN_LO: begin
                    if (byte_valid) begin
                        tmo <= TMO_LOAD;
                        if (!len_valid(len_rx, MAX_WORDS)) begin
                            status <= ST_LEN_ERR;
                            state  <= DRAIN;
                        end else begin
                            len      <= len_rx;
                            word_cnt <= '0;
                            byte_cnt <= '0;
                            state    <= RX_DATA;
                        end
                    end else if (tmo == '0) begin
                        status <= ST_TIMEOUT;
                        state  <= ACK;
                    end
                end

                RX_DATA: begin
                    if (byte_valid) begin
                        tmo            <= TMO_LOAD;
                        bus.tx_data_in <= {bus.tx_data_in[23:0], byte_data};
                        byte_cnt       <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state <= WR_WORD;
                    end else if (tmo == '0) begin
                        bus.tx_clear <= 1'b1;
                        status       <= ST_TIMEOUT;
                        state        <= ACK;
                    end
                end

                WR_WORD: begin
                    if (bus.tx_ready_to_write) begin
                        bus.tx_valid <= 1'b1;
                        word_cnt     <= word_cnt + 16'd1;
                        tmo          <= TMO_LOAD;
                        if (word_cnt + 16'd1 == len)
                            state <= WAIT_RTS;
                        else
                            state <= RX_DATA;
                    end
                end

                WAIT_RTS: begin
                    if (bus.tx_ready_to_send) begin
                        bus.tx_send <= 1'b1;
                        tmo         <= TMO_LOAD;
                        state       <= WAIT_DONE;
                    end
                end

                // tx_done is tested first so a pulse on the expiry cycle still counts as success.
                WAIT_DONE: begin
                    if (bus.tx_done) begin
                        status      <= ST_OK;
                        frames_sent <= frames_sent + 16'd1;
                        state       <= ACK;
                    end else if (tmo == '0) begin
                        bus.tx_clear <= 1'b1;
                        status       <= ST_NO_DONE;
                        state        <= ACK;
                    end
                end

                DRAIN: begin
                    if (byte_valid)
                        tmo <= TMO_LOAD;
                    else if (tmo == '0)
                        state <= ACK;
                end

                ACK: begin
                    if (!bus.uart_tx_busy) begin
                        bus.uart_din   <= status;
                        bus.uart_wr_en <= 1'b1;
                        ack_cnt        <= '0;
                        ack_seen       <= 1'b0;
                        state          <= ACK_WAIT;
                    end
                end

                // A transmitter that never reports busy must not wedge the loader.
                ACK_WAIT: begin
                    if (ack_seen) begin
                        if (!bus.uart_tx_busy)
                            state <= IDLE;
                    end else if (bus.uart_tx_busy) begin
                        ack_seen <= 1'b1;
                    end else if (ack_cnt == 5'(ACK_WAIT_LIMIT - 1)) begin
                        state <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 5'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_eth_tx_loader.sv
// Randomised and directed frames against a frame-level reference model of the
// host protocol, with UART and Ethernet buffer behaviour emulated around the loader.
module tb_uart_eth_tx_loader;

    localparam int TMO  = 300;
    localparam int MAXW = 512;

    logic        clk_100_mhz = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] frames_sent;

    uart_eth_tx_loader_if bus();

    uart_eth_tx_loader #(
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_100_mhz (clk_100_mhz),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk_100_mhz = ~clk_100_mhz;

    int total = 0;
    int bad   = 0;

    logic [31:0] seen_words[$];
    logic [7:0]  seen_status[$];
    int          send_total = 0;
    int          clr_total  = 0;
    int          ack_total  = 0;
    int          viol       = 0;

    logic [7:0]  frame_q[$];
    int          done_mode;
    int          done_delay;
    logic        hold_mode;
    logic        tx_mute;

    logic [31:0] exp_words[$];
    logic [7:0]  exp_status;
    int          exp_send;
    int          exp_clear;
    int          model_frames;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observer: records every strobe of interest and flags any strobe held two cycles running.
    initial begin
        logic [4:0] strobes, prev;
        prev = '0;
        forever begin
            @(negedge clk_100_mhz);
            if (!rst) begin
                strobes = {bus.tx_valid, bus.tx_send, bus.tx_clear, bus.uart_wr_en, bus.uart_rdy_clr};
                if ((strobes & prev) != 5'd0) viol++;
                prev = strobes;
                if (bus.tx_valid)     seen_words.push_back(bus.tx_data_in);
                if (bus.tx_send)      send_total++;
                if (bus.tx_clear)     clr_total++;
                if (bus.uart_rdy_clr) ack_total++;
                if (bus.uart_wr_en)   seen_status.push_back(bus.uart_din);
            end else begin
                prev = '0;
            end
        end
    end

    // UART transmitter: goes busy for a few cycles after each write unless muted.
    initial begin
        bus.uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk_100_mhz);
            if (bus.uart_wr_en && !rst && !tx_mute) begin
                bus.uart_tx_busy = 1'b1;
                repeat ($urandom_range(2, 8)) @(negedge clk_100_mhz);
                bus.uart_tx_busy = 1'b0;
            end
        end
    end

    // Ethernet MAC: mode 0 pulses tx_done after done_delay cycles, 1 never, 2 on the timeout expiry cycle.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk_100_mhz);
            if (bus.tx_send && !rst && done_mode != 1) begin
                if (done_mode == 0)
                    repeat (done_delay - 1) @(negedge clk_100_mhz);
                else
                    repeat (TMO - 1) @(negedge clk_100_mhz);
                bus.tx_done = 1'b1;
                @(negedge clk_100_mhz);
                bus.tx_done = 1'b0;
            end
        end
    end

    task automatic buildExpected();
        int n, full;
        exp_words.delete();
        exp_send  = 0;
        exp_clear = 0;
        if (frame_q.size() < 2) begin
            exp_status = 8'hE2;
            return;
        end
        n = int'(frame_q[0]) * 256 + int'(frame_q[1]);
        if (n == 0 || n > MAXW) begin
            exp_status = 8'hE1;
            return;
        end
        full = (frame_q.size() - 2) / 4;
        if (full > n) full = n;
        for (int w = 0; w < full; w++)
            exp_words.push_back({frame_q[2+4*w], frame_q[3+4*w], frame_q[4+4*w], frame_q[5+4*w]});
        if (full < n) begin
            exp_status = 8'hE2;
            exp_clear  = 1;
            return;
        end
        exp_send = 1;
        if (done_mode == 1) begin
            exp_status = 8'hE3;
            exp_clear  = 1;
        end else begin
            exp_status = 8'hA5;
            model_frames = (model_frames + 1) % 65536;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic got;
        got = 1'b0;
        bus.uart_dout = b;
        bus.uart_rdy  = 1'b1;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk_100_mhz);
            got = bus.uart_rdy_clr;
        end
        checkOutput("byte_ack", {31'd0, got}, 32'd1);
        bus.uart_rdy = 1'b0;
        @(negedge clk_100_mhz);
    endtask

    task automatic applyStimulus(input string name);
        int ack0, word0, stat0, send0, clr0, k;
        logic [31:0] snap, obs;
        logic stable, fired;
        ack0  = ack_total;
        word0 = seen_words.size();
        stat0 = seen_status.size();
        send0 = send_total;
        clr0  = clr_total;
        buildExpected();
        if (hold_mode) bus.tx_ready_to_write = 1'b0;
        fork
            begin
                foreach (frame_q[i]) begin
                    send_byte(frame_q[i]);
                    repeat ($urandom_range(0, 4)) @(negedge clk_100_mhz);
                end
            end
            begin
                if (hold_mode) begin
                    k = 0;
                    while (ack_total - ack0 < 6 && k < 3000) begin
                        @(negedge clk_100_mhz);
                        k++;
                    end
                    snap   = bus.tx_data_in;
                    stable = 1'b1;
                    fired  = 1'b0;
                    repeat (100) begin
                        @(negedge clk_100_mhz);
                        if (bus.tx_valid) fired = 1'b1;
                        if (bus.tx_data_in !== snap) stable = 1'b0;
                    end
                    checkOutput("hold_no_valid", {31'd0, fired}, 32'd0);
                    checkOutput("hold_stable", {31'd0, stable}, 32'd1);
                    checkOutput("hold_data", snap, exp_words[0]);
                    bus.tx_ready_to_write = 1'b1;
                end
            end
        join
        k = 0;
        while (seen_status.size() == stat0 && k < 5000) begin
            @(negedge clk_100_mhz);
            k++;
        end
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk_100_mhz);
            k++;
        end
        checkOutput({name, "_status_cnt"}, 32'(seen_status.size() - stat0), 32'd1);
        checkOutput({name, "_status"}, (seen_status.size() > stat0) ? {24'd0, seen_status[stat0]} : 32'd0,
                    {24'd0, exp_status});
        checkOutput({name, "_word_cnt"}, 32'(seen_words.size() - word0), 32'(exp_words.size()));
        foreach (exp_words[i]) begin
            obs = (word0 + i < seen_words.size()) ? seen_words[word0+i] : 32'd0;
            checkOutput({name, "_word"}, obs, exp_words[i]);
        end
        checkOutput({name, "_send"}, 32'(send_total - send0), 32'(exp_send));
        checkOutput({name, "_clear"}, 32'(clr_total - clr0), 32'(exp_clear));
        checkOutput({name, "_acks"}, 32'(ack_total - ack0), 32'(frame_q.size()));
        checkOutput({name, "_frames"}, {16'd0, frames_sent}, 32'(model_frames));
        checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
        hold_mode = 1'b0;
        tx_mute   = 1'b0;
        done_mode = 0;
    endtask

    initial begin
        int n, cut;
        rst = 1'b1;
        bus.uart_rdy = 1'b0;
        bus.uart_dout = 8'h00;
        bus.tx_ready_to_write = 1'b1;
        bus.tx_ready_to_send = 1'b1;
        done_mode = 0;
        done_delay = 50;
        hold_mode = 1'b0;
        tx_mute = 1'b0;
        model_frames = 0;
        repeat (3) @(negedge clk_100_mhz);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_frames", {16'd0, frames_sent}, 32'd0);
        checkOutput("rst_data", bus.tx_data_in, 32'd0);
        checkOutput("rst_din", {24'd0, bus.uart_din}, 32'd0);
        checkOutput("rst_strobes", {27'd0, bus.tx_valid, bus.tx_send, bus.tx_clear, bus.uart_wr_en, bus.uart_rdy_clr}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_100_mhz);

        frame_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        done_delay = 50;
        applyStimulus("two_words");

        frame_q = '{8'h00, 8'h00};
        applyStimulus("len_zero");

        frame_q = '{8'h02, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        applyStimulus("len_513");

        frame_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        applyStimulus("truncated");

        frame_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        hold_mode = 1'b1;
        done_delay = 20;
        applyStimulus("rtw_hold");

        frame_q = '{8'h00, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67};
        done_mode = 1;
        applyStimulus("no_done");

        frame_q = '{8'h00, 8'h01, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        done_mode = 2;
        applyStimulus("done_at_expiry");

        frame_q = '{8'h07};
        applyStimulus("len_lo_timeout");

        frame_q = '{8'h00, 8'h01, 8'h5A, 8'h5A, 8'hA5, 8'hA5};
        tx_mute = 1'b1;
        done_delay = 10;
        applyStimulus("uart_mute");

        // Reset in the middle of payload reception.
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        @(negedge clk_100_mhz);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_frames", {16'd0, frames_sent}, 32'd0);
        checkOutput("midrst_data", bus.tx_data_in, 32'd0);
        checkOutput("midrst_strobes", {27'd0, bus.tx_valid, bus.tx_send, bus.tx_clear, bus.uart_wr_en, bus.uart_rdy_clr}, 32'd0);
        model_frames = 0;
        repeat (2) @(negedge clk_100_mhz);
        rst = 1'b0;
        @(negedge clk_100_mhz);
        frame_q = '{8'h00, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40};
        done_delay = 30;
        applyStimulus("after_reset");

        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 4);
            frame_q.delete();
            frame_q.push_back(8'h00);
            frame_q.push_back(8'(n));
            for (int b = 0; b < 4 * n; b++) frame_q.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                cut = $urandom_range(0, 4 * n - 1);
                while (frame_q.size() > 2 + cut) void'(frame_q.pop_back());
            end
            done_mode  = ($urandom_range(0, 4) == 0) ? 1 : 0;
            done_delay = $urandom_range(1, 100);
            hold_mode  = 1'b0;
            applyStimulus("random");
        end

        checkOutput("strobe_width", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
